// File: rtl/extinguisher_ctrl.sv
// -----------------------------------------------------------------------------
// extinguisher_ctrl
//   Multi-zone fire-suppression controller for one shared extinguisher.
//   Level fire requests from NUM_ZONES zones are arbitrated round-robin. The
//   winning zone goes through ARM -> SPRAY -> COOL, then the controller returns
//   to IDLE. Spray time is metered in extinguisher-active cycles, with a
//   watchdog that ends SPRAY if the extinguisher never reports enough activity.
//
// Ports
//   clk         in   1          system clock, rising edge
//   clr         in   1          asynchronous, active-high reset
//   fire_req    in   NUM_ZONES  level request per zone (bit i = zone i)
//   abort       in   1          manual abort, level
//   ext_active  in   1          extinguisher is spraying
//   ext_enable  out  1          enable to the extinguisher (high in SPRAY)
//   zone        out  ZONE_W     index of the granted zone (holds after release)
//   grant       out  NUM_ZONES  one-hot grant, 0 when idle
//   busy        out  1          high in ARM / SPRAY / COOL
//   done        out  1          one-cycle pulse on COOL -> IDLE
//   fault       out  1          spray watchdog expired; cleared on next grant
// -----------------------------------------------------------------------------
module extinguisher_ctrl #(
  parameter  int ZONE_W       = 2,
  parameter  int ARM_CYCLES   = 4,
  parameter  int SPRAY_CYCLES = 16,
  parameter  int COOL_CYCLES  = 8,
  localparam int NUM_ZONES    = 2 ** ZONE_W
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NUM_ZONES-1:0] fire_req,
  input  logic                 abort,
  input  logic                 ext_active,
  output logic                 ext_enable,
  output logic [ZONE_W-1:0]    zone,
  output logic [NUM_ZONES-1:0] grant,
  output logic                 busy,
  output logic                 done,
  output logic                 fault
);

  // Watchdog horizon: four times the nominal spray length.
  localparam int WD_CYCLES = 4 * SPRAY_CYCLES;

  // The shared state counter must hold the largest per-state count.
  localparam int CNT_MAX_AC = (ARM_CYCLES > COOL_CYCLES) ? ARM_CYCLES : COOL_CYCLES;
  localparam int CNT_MAX    = (WD_CYCLES > CNT_MAX_AC) ? WD_CYCLES : CNT_MAX_AC;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SPRAY_LAST = CNT_W'(SPRAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'(WD_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_SPRAY = 2'd2;
  localparam logic [1:0] S_COOL  = 2'd3;

  // One-hot decode of a zone index.
  function automatic logic [NUM_ZONES-1:0] zone_onehot(input logic [ZONE_W-1:0] z);
    zone_onehot = {{(NUM_ZONES-1){1'b0}}, 1'b1} << z;
  endfunction

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  cnt_r;        // cycles in current state; doubles as spray watchdog
  logic [CNT_W-1:0]  spray_cnt_r;  // ext_active-high cycles seen in SPRAY
  logic [ZONE_W-1:0] rr_r;         // zone that last completed a full sequence

  logic [1:0]        next_state_s;
  logic              fault_set_s;
  logic              state_change_s;
  logic              issue_grant_s;
  logic              release_s;
  logic              complete_s;
  logic [ZONE_W-1:0] cand_s;
  logic [ZONE_W-1:0] pick_zone_s;
  logic              pick_valid_s;

  // Round-robin pick: first requesting zone scanning upward from rr_r+1 with wrap.
  always_comb begin
    cand_s       = {ZONE_W{1'b0}};
    pick_zone_s  = {ZONE_W{1'b0}};
    pick_valid_s = 1'b0;
    for (int i = 1; i <= NUM_ZONES; i++) begin
      // Index arithmetic wraps naturally at ZONE_W bits, giving the mod.
      cand_s       = rr_r + ZONE_W'(i);
      pick_zone_s  = (!pick_valid_s && fire_req[cand_s]) ? cand_s : pick_zone_s;
      pick_valid_s = pick_valid_s | fire_req[cand_s];
    end
  end

  // Next-state decision; same-edge priority in SPRAY is abort, completion, watchdog.
  always_comb begin
    next_state_s = state_r;
    fault_set_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!abort && pick_valid_s) begin
          next_state_s = S_ARM;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_ARM: begin
        // Losing the request or an abort cancels before anything sprays.
        if (abort || !fire_req[zone]) begin
          next_state_s = S_IDLE;
        end else if (cnt_r == ARM_LAST) begin
          next_state_s = S_SPRAY;
        end else begin
          next_state_s = S_ARM;
        end
      end
      S_SPRAY: begin
        // fire_req is deliberately not consulted: a started spray always finishes.
        if (abort) begin
          next_state_s = S_COOL;
        end else if (ext_active && (spray_cnt_r == SPRAY_LAST)) begin
          next_state_s = S_COOL;
        end else if (cnt_r == WD_LAST) begin
          next_state_s = S_COOL;
          fault_set_s  = 1'b1;
        end else begin
          next_state_s = S_SPRAY;
        end
      end
      S_COOL: begin
        if (cnt_r == COOL_LAST) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_COOL;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // Event decode shared by the register blocks below.
  always_comb begin
    state_change_s = (next_state_s != state_r);
    issue_grant_s  = (state_r == S_IDLE) && (next_state_s == S_ARM);
    release_s      = (state_r != S_IDLE) && (next_state_s == S_IDLE);
    complete_s     = (state_r == S_COOL) && (next_state_s == S_IDLE);
  end

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // State counter: cleared on every state change, parked at zero in IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (state_change_s || (state_r == S_IDLE)) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Spray meter: counts extinguisher-active cycles while in SPRAY.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      spray_cnt_r <= CNT_ZERO;
    end else if (state_change_s) begin
      spray_cnt_r <= CNT_ZERO;
    end else if ((state_r == S_SPRAY) && ext_active) begin
      spray_cnt_r <= spray_cnt_r + CNT_ONE;
    end else begin
      spray_cnt_r <= spray_cnt_r;
    end
  end

  // Round-robin pointer moves only when a sequence completes through COOL.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rr_r <= {ZONE_W{1'b1}};
    end else if (complete_s) begin
      rr_r <= zone;
    end else begin
      rr_r <= rr_r;
    end
  end

  // Grant and zone outputs; zone keeps its last value after release.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      grant <= {NUM_ZONES{1'b0}};
      zone  <= {ZONE_W{1'b0}};
    end else if (issue_grant_s) begin
      grant <= zone_onehot(pick_zone_s);
      zone  <= pick_zone_s;
    end else if (release_s) begin
      grant <= {NUM_ZONES{1'b0}};
      zone  <= zone;
    end else begin
      grant <= grant;
      zone  <= zone;
    end
  end

  // Status outputs derived from the state being entered.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ext_enable <= (next_state_s == S_SPRAY);
      busy       <= (next_state_s != S_IDLE);
      done       <= complete_s;
    end
  end

  // Fault flag: set by watchdog expiry, held until the next grant.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fault <= 1'b0;
    end else if (issue_grant_s) begin
      fault <= 1'b0;
    end else if (fault_set_s) begin
      fault <= 1'b1;
    end else begin
      fault <= fault;
    end
  end

endmodule

// File: tb/tb_extinguisher_ctrl.sv
// -----------------------------------------------------------------------------
// tb_extinguisher_ctrl
//   Directed scenarios followed by randomized traffic. Every cycle the DUT
//   outputs are compared with a phase/countdown reference model; directed
//   scenarios add explicit checks of grant order, durations and pulses.
// -----------------------------------------------------------------------------
module tb_extinguisher_ctrl;

  localparam int NZ     = 4;
  localparam int ARM_N  = 4;
  localparam int SPR_N  = 16;
  localparam int COOL_N = 8;
  localparam int WD_N   = 4 * SPR_N;

  logic           clk;
  logic           clr;
  logic [NZ-1:0]  fire_req;
  logic           abort;
  logic           ext_active;
  logic           ext_enable;
  logic [1:0]     zone;
  logic [NZ-1:0]  grant;
  logic           busy;
  logic           done;
  logic           fault;

  extinguisher_ctrl dut (
    .clk        (clk),
    .clr        (clr),
    .fire_req   (fire_req),
    .abort      (abort),
    .ext_active (ext_active),
    .ext_enable (ext_enable),
    .zone       (zone),
    .grant      (grant),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: phase plus countdowns of what remains in that phase.
  typedef enum int {PH_IDLE, PH_ARM, PH_SPRAY, PH_COOL} phase_t;
  phase_t m_phase;
  int     m_left;     // cycles remaining in ARM or COOL
  int     m_need;     // active cycles still needed in SPRAY
  int     m_wd;       // SPRAY cycles until watchdog
  int     m_rr;
  int     m_zone;
  bit     m_fault;
  bit     m_done;

  int     act_mode;   // 0 tied low, 1 tied high, 2 8-high/8-low, 3 random
  int     en_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_left  = 0;
    m_need  = 0;
    m_wd    = 0;
    m_rr    = NZ - 1;
    m_zone  = 0;
    m_fault = 1'b0;
    m_done  = 1'b0;
    en_cyc  = 0;
  endtask

  task automatic model_step(input logic [NZ-1:0] f, input logic a, input logic act);
    bit found;
    int z;
    m_done = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        if (!a && f != 4'b0000) begin
          found = 1'b0;
          for (int k = 1; k <= NZ; k++) begin
            z = (m_rr + k) % NZ;
            if (!found && f[z]) begin
              found  = 1'b1;
              m_zone = z;
            end
          end
          m_phase = PH_ARM;
          m_left  = ARM_N;
          m_fault = 1'b0;
        end
      end
      PH_ARM: begin
        if (a || !f[m_zone]) begin
          m_phase = PH_IDLE;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_phase = PH_SPRAY;
            m_need  = SPR_N;
            m_wd    = WD_N;
          end
        end
      end
      PH_SPRAY: begin
        m_wd--;
        if (act) m_need--;
        if (a) begin
          m_phase = PH_COOL;
        end else if (act && m_need == 0) begin
          m_phase = PH_COOL;
        end else if (m_wd == 0) begin
          m_phase = PH_COOL;
          m_fault = 1'b1;
        end
        if (m_phase == PH_COOL) m_left = COOL_N;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_phase = PH_IDLE;
          m_done  = 1'b1;
          m_rr    = m_zone;
        end
      end
    endcase
  endtask

  // One clock: check outputs at the falling edge, then drive inputs for the next rise.
  task automatic cyc(input logic [NZ-1:0] f, input logic a);
    logic act;
    logic pat;
    @(negedge clk);
    chk("m_ext_enable", ext_enable, m_phase == PH_SPRAY);
    chk("m_busy", busy, m_phase != PH_IDLE);
    chk("m_grant", grant, (m_phase != PH_IDLE) ? (32'd1 << m_zone) : 32'd0);
    chk("m_zone", zone, m_zone);
    chk("m_done", done, m_done);
    chk("m_fault", fault, m_fault);
    if (m_phase == PH_SPRAY) begin
      pat = ((en_cyc / 8) % 2) == 0;
      en_cyc++;
    end else begin
      pat    = 1'b0;
      en_cyc = 0;
    end
    case (act_mode)
      0:       act = 1'b0;
      1:       act = 1'b1;
      2:       act = pat;
      default: act = 1'($urandom_range(0, 1));
    endcase
    fire_req   = f;
    abort      = a;
    ext_active = act;
    model_step(f, a, act);
  endtask

  initial begin
    int n;
    int n_en;
    int n_cool;
    int n_done;
    int idle_run;
    bit en_seen;
    bit done_seen;
    logic prev_busy;
    logic [NZ-1:0] rf;
    int gz[$];

    clr = 1'b1; fire_req = 4'b0000; abort = 1'b0; ext_active = 1'b0;
    act_mode = 0;
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // Single zone with the 8-high/8-low extinguisher.
    act_mode = 2;
    n = 0;
    while (!busy && n < 10) begin cyc(4'b0100, 1'b0); n++; end
    chk("t2_grant_seen", busy, 1);
    chk("t2_zone", zone, 2);
    chk("t2_grant", grant, 4'b0100);
    n = 0;
    while (!ext_enable && n < 20) begin cyc(4'b0100, 1'b0); n++; end
    chk("t2_arm_len", n, ARM_N);
    n_en = 0; n_cool = 0; n_done = 0;
    for (int i = 0; i < 60; i++) begin
      if (ext_enable) n_en++;
      if (busy && !ext_enable) n_cool++;
      if (done) n_done++;
      cyc(4'b0000, 1'b0);
    end
    chk("t2_spray_len", n_en, 24);
    chk("t2_cool_len", n_cool, COOL_N);
    chk("t2_done_pulses", n_done, 1);

    // Asynchronous reset between edges while spraying.
    act_mode = 1;
    n = 0;
    while (!ext_enable && n < 20) begin cyc(4'b0100, 1'b0); n++; end
    chk("t1_in_spray", ext_enable, 1);
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b0);
    #2;
    clr = 1'b1; fire_req = 4'b0000; abort = 1'b0; ext_active = 1'b0;
    #1;
    chk("t1_rst_ext_enable", ext_enable, 0);
    chk("t1_rst_grant", grant, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_done", done, 0);
    chk("t1_rst_fault", fault, 0);
    chk("t1_rst_zone", zone, 0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;

    // Fairness with all zones requesting.
    act_mode = 1;
    prev_busy = busy;
    idle_run = 0;
    for (int i = 0; i < 400 && gz.size() < 5; i++) begin
      cyc(4'b1111, 1'b0);
      if (busy && !prev_busy) begin
        if (gz.size() > 0) chk("t3_gap", idle_run >= 1, 1);
        gz.push_back(int'(zone));
        idle_run = 0;
      end else if (!busy) begin
        idle_run++;
      end
      prev_busy = busy;
    end
    chk("t3_grant_count", gz.size(), 5);
    for (int k = 0; k < gz.size(); k++) chk("t3_order", gz[k], k % NZ);
    repeat (3) cyc(4'b0000, 1'b0);

    // Abort on the fifth SPRAY cycle.
    act_mode = 1;
    n = 0;
    while (!ext_enable && n < 30) begin cyc(4'b0010, 1'b0); n++; end
    chk("t4_in_spray", ext_enable, 1);
    repeat (3) cyc(4'b0010, 1'b0);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b0);
    chk("t4_enable_off", ext_enable, 0);
    chk("t4_busy", busy, 1);
    n_cool = 0; n = 0;
    while (!done && n < 20) begin
      if (busy && !ext_enable) n_cool++;
      cyc(4'b0000, 1'b0);
      n++;
    end
    chk("t4_done", done, 1);
    chk("t4_cool_len", n_cool, COOL_N);
    chk("t4_fault", fault, 0);

    // Watchdog with a silent extinguisher.
    act_mode = 0;
    n = 0;
    while (!ext_enable && n < 30) begin cyc(4'b0001, 1'b0); n++; end
    n = 0;
    while (ext_enable && n < 100) begin n++; cyc(4'b0001, 1'b0); end
    chk("t5_spray_len", n, WD_N);
    chk("t5_fault_set", fault, 1);
    n = 0;
    while (!done && n < 20) begin cyc(4'b0000, 1'b0); n++; end
    chk("t5_done", done, 1);
    chk("t5_fault_held", fault, 1);
    cyc(4'b0001, 1'b0);
    cyc(4'b0000, 1'b0);
    chk("t5_regrant", busy, 1);
    chk("t5_fault_clr", fault, 0);
    repeat (2) cyc(4'b0000, 1'b0);

    // Cancel in ARM; the pointer must not advance.
    act_mode = 1;
    n = 0;
    while (!busy && n < 10) begin cyc(4'b0010, 1'b0); n++; end
    chk("t6_zone", zone, 1);
    cyc(4'b0000, 1'b0);
    en_seen = 1'b0; done_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0000, 1'b0);
      if (i == 0) begin
        chk("t6_cancel_busy", busy, 0);
        chk("t6_cancel_grant", grant, 0);
      end
      en_seen   = en_seen | ext_enable;
      done_seen = done_seen | done;
    end
    chk("t6_no_enable", en_seen, 0);
    chk("t6_no_done", done_seen, 0);
    n = 0;
    while (!busy && n < 10) begin cyc(4'b1110, 1'b0); n++; end
    chk("t6_regrant_zone", zone, 1);
    repeat (2) cyc(4'b0000, 1'b0);

    // Randomized traffic against the model.
    rf = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) act_mode = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) begin
        rf = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) rf = 4'b0000;
      end
      cyc(rf, $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
